// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin client arbiter with one outstanding bus transaction
module memory_bus_arbiter #(
    parameter int N_PORTS   = 4,
    parameter int SRC_W     = 2,
    parameter int ADDR_W    = 32,
    parameter int PAYLOAD_W = 64,
    parameter int TIMEOUT   = 255,
    localparam int PKT_W    = 2 + SRC_W + ADDR_W + PAYLOAD_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [N_PORTS-1:0]             cli_req_valid,
    input  logic [N_PORTS-1:0]             cli_req_write,
    input  logic [N_PORTS*ADDR_W-1:0]      cli_req_addr,
    input  logic [N_PORTS*PAYLOAD_W-1:0]   cli_req_payload,
    output logic [N_PORTS-1:0]             cli_req_accept,
    output logic [N_PORTS-1:0]             cli_rsp_valid,
    output logic [PAYLOAD_W-1:0]           cli_rsp_payload,
    input  logic                           bus_request_busy,
    output logic                           bus_send_request,
    output logic [PKT_W-1:0]               bus_req_pkt,
    input  logic                           bus_response_busy,
    input  logic [PKT_W-1:0]               bus_rsp_pkt,
    output logic                           bus_get_response,
    output logic                           bus_error
);
    typedef enum logic {IDLE, WAIT_RSP} state_t;

    state_t               state, state_nx;
    logic [SRC_W-1:0]     rr_ptr, rr_nx, pend_src, pend_nx, g;
    logic [7:0]           timer, timer_nx;
    logic [N_PORTS-1:0]   req, accept_nx, rsp_valid_nx;
    logic [PAYLOAD_W-1:0] payload_nx;
    logic [PKT_W-1:0]     pkt_nx;
    logic                 any, wr, grant_ok, rsp_seen, rsp_ok, rsp_bad, tmo, get_nx, err_nx;
    logic [1:0]           rsp_type;
    logic [SRC_W-1:0]     rsp_src;
    logic                 unused_rsp_addr;

    assign rsp_type        = bus_rsp_pkt[PKT_W-1 -: 2];
    assign rsp_src         = bus_rsp_pkt[PAYLOAD_W+ADDR_W +: SRC_W];
    assign unused_rsp_addr = ^bus_rsp_pkt[PAYLOAD_W +: ADDR_W];

    // A client whose accept pulse is still showing has not yet dropped valid, and a
    // response being consumed this cycle is still in the slot; neither may be seen twice.
    assign req      = cli_req_valid & ~cli_req_accept;
    assign rsp_seen = bus_response_busy && !bus_get_response;

    // Round-robin pick: first requesting client at or after rr_ptr
    always_comb begin
        g   = '0;
        any = 1'b0;
        for (int i = N_PORTS-1; i >= 0; i--)
            if (req[(int'(rr_ptr)+i)%N_PORTS]) begin
                any = 1'b1;
                g   = SRC_W'((int'(rr_ptr)+i)%N_PORTS);
            end
    end

    assign wr       = cli_req_write[g];
    assign grant_ok = state == IDLE && any && !bus_request_busy;
    assign rsp_ok   = state == WAIT_RSP && rsp_seen && rsp_type == 2'd2 && rsp_src == pend_src;
    assign rsp_bad  = rsp_seen && !rsp_ok;
    assign tmo      = state == WAIT_RSP && !rsp_ok && timer == 8'(TIMEOUT-1);

    // State and output registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            pend_src         <= '0;
            timer            <= '0;
            cli_req_accept   <= '0;
            cli_rsp_valid    <= '0;
            cli_rsp_payload  <= '0;
            bus_send_request <= 1'b0;
            bus_req_pkt      <= '0;
            bus_get_response <= 1'b0;
            bus_error        <= 1'b0;
        end else begin
            state            <= state_nx;
            rr_ptr           <= rr_nx;
            pend_src         <= pend_nx;
            timer            <= timer_nx;
            cli_req_accept   <= accept_nx;
            cli_rsp_valid    <= rsp_valid_nx;
            cli_rsp_payload  <= payload_nx;
            bus_send_request <= grant_ok;
            bus_req_pkt      <= pkt_nx;
            bus_get_response <= get_nx;
            bus_error        <= err_nx;
        end
    end

    // Next state: reads wait for a response, writes stay idle; response beats timeout
    always_comb begin
        state_nx = grant_ok && !wr ? WAIT_RSP : (rsp_ok || tmo) ? IDLE : state;
        rr_nx    = !grant_ok ? rr_ptr : (int'(g) == N_PORTS-1) ? '0 : g + 1'b1;
        pend_nx  = grant_ok ? g : pend_src;
        timer_nx = grant_ok ? '0 : state == WAIT_RSP ? timer + 8'd1 : timer;
    end

    // Next outputs: pulses for one cycle, packet and read data hold their last value
    always_comb begin
        accept_nx    = grant_ok ? N_PORTS'(1) << g : '0;
        pkt_nx       = grant_ok ? {1'b0, wr, g, cli_req_addr[int'(g)*ADDR_W +: ADDR_W],
                                   wr ? cli_req_payload[int'(g)*PAYLOAD_W +: PAYLOAD_W] : PAYLOAD_W'(0)}
                                : bus_req_pkt;
        get_nx       = rsp_seen;
        rsp_valid_nx = rsp_ok ? N_PORTS'(1) << pend_src : '0;
        payload_nx   = rsp_ok ? bus_rsp_pkt[PAYLOAD_W-1:0] : cli_rsp_payload;
        err_nx       = bus_error || rsp_bad || tmo;
    end
endmodule

// File: tb/tb_memory_bus_arbiter.sv
// tb_memory_bus_arbiter: directed vector table plus hand sequences for the arbiter
module tb_memory_bus_arbiter;
    localparam int N = 4, SW = 2, AW = 32, PW = 64, KW = 2 + SW + AW + PW;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   valid, write, accept, rsp_valid;
    logic [N-1:0][AW-1:0] addr_a;
    logic [N-1:0][PW-1:0] pay_a;
    logic [PW-1:0]  rsp_payload;
    logic           rq_busy, send, rs_busy, get, err;
    logic [KW-1:0]  req_pkt, rsp_pkt;

    int checks = 0;
    int errors = 0;

    memory_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cli_req_valid(valid), .cli_req_write(write),
        .cli_req_addr(addr_a), .cli_req_payload(pay_a),
        .cli_req_accept(accept), .cli_rsp_valid(rsp_valid), .cli_rsp_payload(rsp_payload),
        .bus_request_busy(rq_busy), .bus_send_request(send), .bus_req_pkt(req_pkt),
        .bus_response_busy(rs_busy), .bus_rsp_pkt(rsp_pkt),
        .bus_get_response(get), .bus_error(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] valid, write;
        logic         rq_busy, rs_busy;
        logic [N-1:0] acc;
        logic         get, err;
    } vec_t;

    vec_t vecs [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KW-1:0] mk_pkt(input logic [1:0] t, input logic [SW-1:0] s,
                                             input logic [AW-1:0] a, input logic [PW-1:0] p);
        return {t, s, a, p};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        valid = '0; write = '0; rq_busy = 1'b0; rs_busy = 1'b0; rsp_pkt = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic all_zero(input string name);
        chk({name, " outputs"}, {accept, rsp_valid, send, get, err}, '0);
        chk({name, " pkt"}, req_pkt, '0);
        chk({name, " payload"}, rsp_payload, '0);
    endtask

    initial begin
        logic [SW-1:0] gi;
        logic ok;
        for (int i = 0; i < N; i++) begin
            addr_a[i] = 32'h1000 + 32'(i) * 32'h10;
            pay_a[i]  = 64'h5A00 + 64'(i);
        end
        vecs[0]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        vecs[1]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b0};
        vecs[2]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b0};
        vecs[3]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b0};
        vecs[4]  = '{4'b1111, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        for (int i = 5; i < 10; i++)
            vecs[i] = '{4'b0001, 4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[10] = '{4'b0001, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0};
        vecs[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0};
        vecs[12] = '{4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1};

        reset_n = 1'b0;
        valid = 4'b1111; write = 4'b1111; rq_busy = 1'b0; rs_busy = 1'b0; rsp_pkt = '0;
        #1;
        for (int i = 0; i < 3; i++) begin
            step();
            all_zero("reset");
        end
        reset_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            valid = vecs[v].valid; write = vecs[v].write;
            rq_busy = vecs[v].rq_busy; rs_busy = vecs[v].rs_busy;
            step();
            chk($sformatf("vec%0d accept", v), accept, vecs[v].acc);
            chk($sformatf("vec%0d send", v), send, |vecs[v].acc);
            chk($sformatf("vec%0d get/err", v), {get, err}, {vecs[v].get, vecs[v].err});
            if (vecs[v].acc != 0) begin
                gi = '0;
                for (int i = 0; i < N; i++) if (vecs[v].acc[i]) gi = SW'(i);
                chk($sformatf("vec%0d pkt", v), req_pkt,
                    mk_pkt(2'd1, gi, addr_a[gi], pay_a[gi]));
            end
        end

        do_reset();
        addr_a[1] = 32'h100;
        valid = 4'b0010; write = 4'b0000;
        step();
        chk("read accept", {accept, send}, {4'b0010, 1'b1});
        chk("read pkt", req_pkt, mk_pkt(2'd0, 2'd1, 32'h100, 64'd0));
        valid = '0;
        step();
        chk("read gap", {accept, rsp_valid, get}, '0);
        rs_busy = 1'b1; rsp_pkt = mk_pkt(2'd2, 2'd1, 32'd0, 64'hDEAD);
        step();
        chk("read rsp", {rsp_valid, get, accept}, {4'b0010, 1'b1, 4'b0000});
        chk("read payload", rsp_payload, 64'hDEAD);
        rs_busy = 1'b0;
        step();
        chk("read done", {rsp_valid, get, err}, '0);
        chk("read payload hold", rsp_payload, 64'hDEAD);

        valid = 4'b1100; write = 4'b1000;
        step();
        chk("tmo accept", accept, 4'b0100);
        valid = 4'b1000;
        ok = 1'b1;
        for (int k = 1; k < 255; k++) begin
            step();
            if (accept != 0 || err || rsp_valid != 0) ok = 1'b0;
        end
        chk("tmo wait quiet", ok, 1'b1);
        step();
        chk("tmo error", {err, accept, rsp_valid}, {1'b1, 4'b0000, 4'b0000});
        step();
        chk("tmo next grant", {accept, send}, {4'b1000, 1'b1});
        chk("tmo next pkt", req_pkt, mk_pkt(2'd1, 2'd3, addr_a[3], pay_a[3]));
        valid = '0;

        do_reset();
        valid = 4'b0001; write = 4'b0000;
        step();
        chk("badsrc accept", accept, 4'b0001);
        valid = 4'b0010; write = 4'b0010;
        rs_busy = 1'b1; rsp_pkt = mk_pkt(2'd2, 2'd3, 32'd0, 64'hBAD);
        step();
        chk("badsrc consume", {get, err, rsp_valid, accept}, {1'b1, 1'b1, 4'b0000, 4'b0000});
        rs_busy = 1'b0;
        step();
        chk("badsrc waiting", {get, err, rsp_valid, accept}, {1'b0, 1'b1, 4'b0000, 4'b0000});
        rs_busy = 1'b1; rsp_pkt = mk_pkt(2'd2, 2'd0, 32'd0, 64'h1234);
        step();
        chk("badsrc good rsp", {get, rsp_valid, accept}, {1'b1, 4'b0001, 4'b0000});
        chk("badsrc payload", rsp_payload, 64'h1234);
        rs_busy = 1'b0;
        step();
        chk("badsrc resume", {rsp_valid, accept, err}, {4'b0000, 4'b0010, 1'b1});

        valid = 4'b0100; write = 4'b0000;
        step();
        chk("midrst accept", accept, 4'b0100);
        valid = '0;
        step();
        rs_busy = 1'b1; rsp_pkt = mk_pkt(2'd2, 2'd2, 32'd0, 64'h77);
        reset_n = 1'b0;
        #1;
        all_zero("midrst async");
        step();
        all_zero("midrst held");
        reset_n = 1'b1; rs_busy = 1'b0;
        step();
        chk("midrst after", {rsp_valid, get, err}, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
